// File: rtl/perm_stream_checker_pkg.sv
// rtl/perm_stream_checker_pkg.sv - shared state encoding for the permutation checker
package perm_stream_checker_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_REPORT  = 1'b1
    } state_t;

endpackage

// File: rtl/perm_stream_checker_onehot_decoder.sv
// rtl/perm_stream_checker_onehot_decoder.sv - W-bit index to 2**W one-hot decoder
module onehot_decoder #(
    parameter int W = 2
) (
    input  logic [W-1:0]      sel,
    output logic [2**W-1:0]   onehot
);

    localparam int N = 2 ** W;

    assign onehot = {{(N-1){1'b0}}, 1'b1} << sel;

endmodule

// File: rtl/perm_stream_checker.sv
// rtl/perm_stream_checker.sv - streaming permutation checker with inverse map and fixed-point count
module perm_stream_checker
    import perm_stream_checker_pkg::*;
#(
    parameter int IDXW = 2,
    parameter int N    = 2 ** IDXW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IDXW-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_perm_ok,
    output logic [IDXW:0]       out_fixed_cnt,
    output logic                out_one_fixed,
    output logic [N*IDXW-1:0]   out_inv
);

    state_t              state, state_next;
    logic [IDXW-1:0]     idx;
    logic [N-1:0]        seen;
    logic                dup;
    logic [IDXW:0]       fixed_cnt;
    logic [N*IDXW-1:0]   inv;
    logic [N-1:0]        onehot;
    logic                accept;
    logic                last;
    logic                release_frame;

    onehot_decoder #(.W(IDXW)) u_dec (
        .sel    (in_data),
        .onehot (onehot)
    );

    assign accept        = in_valid & in_ready & ~clr;
    assign last          = (idx == IDXW'(N - 1));
    assign release_frame = (state == ST_REPORT) & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_COLLECT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clr)
            state_next = ST_COLLECT;
        else if (state == ST_COLLECT && accept && last)
            state_next = ST_REPORT;
        else if (release_frame)
            state_next = ST_COLLECT;
    end

    always_comb begin
        in_ready      = (state == ST_COLLECT);
        out_valid     = (state == ST_REPORT);
        out_perm_ok   = out_valid & ~dup;
        out_fixed_cnt = out_valid ? fixed_cnt : '0;
        out_one_fixed = out_valid & ~dup & (fixed_cnt == (IDXW+1)'(1));
        out_inv       = out_valid ? inv : '0;
    end

    // First occurrence of a value claims its inverse slot; later repeats only flag dup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            seen      <= '0;
            dup       <= 1'b0;
            fixed_cnt <= '0;
            inv       <= '0;
        end else if (clr || release_frame) begin
            idx       <= '0;
            seen      <= '0;
            dup       <= 1'b0;
            fixed_cnt <= '0;
            inv       <= '0;
        end else if (accept) begin
            idx <= last ? '0 : idx + 1'b1;
            if (|(seen & onehot))
                dup <= 1'b1;
            seen <= seen | onehot;
            if (in_data == idx)
                fixed_cnt <= fixed_cnt + 1'b1;
            for (int v = 0; v < N; v++) begin
                if (onehot[v] && !seen[v])
                    inv[v*IDXW +: IDXW] <= idx;
            end
        end
    end

endmodule

// File: tb/tb_perm_stream_checker.sv
// tb/tb_perm_stream_checker.sv - directed self-checking bench for perm_stream_checker
module tb_perm_stream_checker;

    localparam int IDXW = 2;
    localparam int N    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [IDXW-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_perm_ok;
    logic [IDXW:0]     out_fixed_cnt;
    logic              out_one_fixed;
    logic [N*IDXW-1:0] out_inv;

    int tests_run  = 0;
    int tests_fail = 0;

    always #5 clk = ~clk;

    perm_stream_checker #(.IDXW(IDXW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (clr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_perm_ok   (out_perm_ok),
        .out_fixed_cnt (out_fixed_cnt),
        .out_one_fixed (out_one_fixed),
        .out_inv       (out_inv)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // s packs the stream with position i at s[2*i +: 2]
    task automatic load(input string tag, input logic [7:0] s);
        logic [7:0] d;
        d = s;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            if (i == N - 1) check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            in_data  = d[2*i +: 2];
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_latency_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic expect_result(input string tag, input logic ok, input logic [2:0] fc,
                                 input logic one, input logic [7:0] inv);
        check({tag, "_perm_ok"}, 32'(out_perm_ok), 32'(ok));
        check({tag, "_fixed_cnt"}, 32'(out_fixed_cnt), 32'(fc));
        check({tag, "_one_fixed"}, 32'(out_one_fixed), 32'(one));
        check({tag, "_inv"}, 32'(out_inv), 32'(inv));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_released_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_released_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int first_cyc, second_cyc, cyc;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_perm_ok", 32'(out_perm_ok), 32'd0);
        check("rst_inv", 32'(out_inv), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        load("t1", 8'h1B);                       // 3,2,1,0
        expect_result("t1", 1'b1, 3'd0, 1'b0, 8'h1B);
        consume("t1");

        load("t2a", 8'hD8);                      // 0,2,1,3
        expect_result("t2a", 1'b1, 3'd2, 1'b0, 8'hD8);
        consume("t2a");
        load("t2b", 8'h78);                      // 0,2,3,1
        expect_result("t2b", 1'b1, 3'd1, 1'b1, 8'h9C);
        consume("t2b");

        load("t3", 8'hE5);                       // 1,1,2,3: positions 1,2,3 are fixed
        expect_result("t3", 1'b0, 3'd3, 1'b0, 8'hE0);
        consume("t3");

        load("t4", 8'h1B);
        in_valid = 1'b1; in_data = 2'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_hold_in_ready", 32'(in_ready), 32'd0);
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            expect_result("t4_hold", 1'b1, 3'd0, 1'b0, 8'h1B);
        end
        consume("t4");
        load("t4_after", 8'hD8);
        expect_result("t4_after", 1'b1, 3'd2, 1'b0, 8'hD8);
        consume("t4_after");

        for (int i = 0; i < 2; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 2'(3 - i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("t5_rst_in_ready", 32'(in_ready), 32'd1);
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_fixed", 32'(out_fixed_cnt), 32'd0);
        check("t5_rst_inv", 32'(out_inv), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load("t5", 8'hE4);                       // 0,1,2,3
        expect_result("t5", 1'b1, 3'd4, 1'b0, 8'hE4);
        consume("t5");

        for (int i = 0; i < 3; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 2'(i);
        end
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; in_data = 2'd3;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        check("t6_clr_valid", 32'(out_valid), 32'd0);
        load("t6", 8'h4E);                       // 2,3,0,1
        expect_result("t6", 1'b1, 3'd0, 1'b0, 8'h4E);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t6_clr_report_valid", 32'(out_valid), 32'd0);
        check("t6_clr_report_ready", 32'(in_ready), 32'd1);

        first_cyc = -1; second_cyc = -1; cyc = 0;
        in_valid = 1'b1; in_data = 2'd1; out_ready = 1'b1;
        while (second_cyc < 0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                else second_cyc = cyc;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("t6_first_valid_cycle", 32'(first_cyc), 32'd4);
        check("t6_frame_period", 32'(second_cyc - first_cyc), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
